fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in bit/s.
REQ-003 Parameter WIDTH, default 8, data bits per frame.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fifo_rd_en  output  1  read strobe to the upstream FIFO.
REQ-007 fifo_dout  input  WIDTH  FIFO read data, valid the cycle after a fifo_rd_en pulse, 0 otherwise.
REQ-008 fifo_empty  input  1  upstream FIFO holds no entries.
REQ-009 serial_out  output  1  UART TX line, idle high.
REQ-010 busy  output  1  high whenever a frame is being fetched or shifted.

Function
REQ-011 Block SHALL drain the FIFO and emit one UART frame per entry: start bit (0), WIDTH data bits LSB first, optional parity bit, one stop bit (1).
REQ-012 Bit period SHALL be SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE cycles (integer division); every bit held exactly that many cycles.
REQ-013 FSM states SHALL be IDLE, FETCH, START, DATA, PARITY (macro builds only), STOP.
REQ-014 IDLE: fifo_empty=0 -> assert fifo_rd_en for exactly one cycle, go to FETCH; fifo_empty=1 -> stay, fifo_rd_en=0.
REQ-015 FETCH: latch fifo_dout into shift register in this cycle (FIFO has one-cycle read latency), go to START next cycle.
REQ-016 START/DATA/PARITY/STOP: advance on bit counter terminal count; DATA advances after bit WIDTH-1.
REQ-017 STOP end -> IDLE; minimum inter-frame gap SHALL be 2 cycles of line-high (IDLE+FETCH).
REQ-018 fifo_rd_en SHALL be high only in IDLE with fifo_empty=0; never during a frame, never when empty.
REQ-019 serial_out SHALL be registered (glitch-free); high in IDLE and FETCH.
REQ-020 busy SHALL be 0 only in IDLE.
REQ-021 Baud counter width SHALL be $clog2(SYMBOL_EDGE_TIME); it SHALL reset to 0 on every state entry.
REQ-022 fifo_empty toggling mid-frame SHALL have no effect until return to IDLE.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, serial_out=1, fifo_rd_en=0, busy=0, counters and shift register 0.
REQ-024 Reset mid-frame SHALL abort the frame; the fetched entry is lost, no partial retransmit after release.
REQ-025 First fifo_rd_en after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-026 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, transmitting even parity (XOR of data bits) for one bit period.
REQ-027 Macro undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state enum and the IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants.
REQ-029 Sub-module uart_baud_tick SHALL implement the bit-period counter (inputs clear, output tick at SYMBOL_EDGE_TIME-1).
REQ-030 FSM, shift register and output register SHALL live in fifo_uart_tx.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100 -> 10 cycles/bit)
REQ-031 FIFO holds 0xA5, no macro -> one rd_en pulse; line 0,1,0,1,0,0,1,0,1,1 each 10 cycles; frame 100 cycles; busy high throughout.
REQ-032 Same with FIFO_UART_TX_PARITY_EN -> parity bit 0 inserted before stop; frame 110 cycles.
REQ-033 FIFO holds 0x01,0xFF back-to-back -> two frames, exactly 2 high cycles between first stop end and second start bit.
REQ-034 fifo_empty held 1 for 500 cycles -> fifo_rd_en never asserts, serial_out stays 1, busy 0.
REQ-035 rst_n pulsed low during bit 3 of 0x3C -> serial_out 1 same cycle (async), FSM IDLE; next frame after release starts with fresh FIFO entry.
REQ-036 Upstream FIFO model drives fifo_dout=0 except cycle after rd_en -> transmitted data matches FIFO contents, never 0x00 from sampling skew.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds the even-parity state).
package uart_pkg;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..SYMBOL_EDGE_TIME-1, ticks on the last count.
module uart_baud_tick #(
    parameter int unsigned SYMBOL_EDGE_TIME = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic [CNT_W-1:0] r_count;

    // Restart on clear (state entry) or after the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == TERM)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tick_c = (r_count == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains an upstream FIFO and serialises each entry as a UART frame.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (even parity bit before stop).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             serial_out,
    output logic             busy
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned IDX_W            = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] w_bit_idx_next;
    logic             r_armed;
    logic             r_serial_out;
    logic             w_serial_next;
    logic             r_busy;
    logic             w_tick;
    logic             w_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             r_parity;
`endif

    // Counter restarts whenever the FSM changes state
    assign w_clear = (w_state_next != r_state);

    uart_baud_tick #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .o_tick_c (w_tick)
    );

    // Next-state, shift and read-strobe decode
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        fifo_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                // r_armed keeps the strobe low until the first edge after reset release
                if (r_armed && !fifo_empty) begin
                    fifo_rd_en   = 1'b1;
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_shift_next   = fifo_dout;
                w_bit_idx_next = '0;
                w_state_next   = START;
            end
            START: begin
                if (w_tick) w_state_next = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                        w_shift_next   = r_shift >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) w_state_next = STOP;
            end
`endif
            STOP: begin
                if (w_tick) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level for the state being entered, so the register lines up with r_state
    always_comb begin
        w_serial_next = IDLE_LEVEL;
        case (w_state_next)
            START:  w_serial_next = START_LEVEL;
            DATA:   w_serial_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: w_serial_next = r_parity;
`endif
            STOP:   w_serial_next = STOP_LEVEL;
            default: w_serial_next = IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_armed      <= 1'b0;
            r_serial_out <= IDLE_LEVEL;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_armed      <= 1'b1;
            r_serial_out <= w_serial_next;
            r_busy       <= (w_state_next != IDLE);
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // Even parity captured alongside the data word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (r_state == FETCH) begin
            r_parity <= ^fifo_dout;
        end
    end
`endif

    assign serial_out = r_serial_out;
    assign busy       = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench for fifo_uart_tx at 10 clocks per bit.
module tb_fifo_uart_tx;

    localparam int BPC = 10;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = '0;
    logic       fifo_empty = 1'b1;
    logic       serial_out;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int rd_en_bad = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    fifo_uart_tx #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100),
        .WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .serial_out(serial_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data only in the cycle after a read strobe, zero otherwise
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_q.size() == 0 || busy) begin
                rd_en_bad <= rd_en_bad + 1;
                fifo_dout <= '0;
            end else begin
                fifo_dout <= fifo_q.pop_front();
            end
        end else begin
            fifo_dout <= '0;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
    endtask

    // Wait for a start bit, then check every cycle of the frame against the scoreboard
    task automatic rx_check(input string name);
        logic [7:0]    exp;
        logic [7:0]    got;
        logic [NB-1:0] bits;
        int            t;
        int            bad_line;
        int            bad_busy;
        t = 0;
        while (serial_out !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL %s start timeout: serial_out=%b required 0", name, serial_out);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected frame: scoreboard size=0 required >0", name);
            return;
        end
        exp = exp_q.pop_front();
`ifdef FIFO_UART_TX_PARITY_EN
        bits = {1'b1, ^exp, exp, 1'b0};
`else
        bits = {1'b1, exp, 1'b0};
`endif
        got      = '0;
        bad_line = 0;
        bad_busy = 0;
        for (int k = 0; k < NB * BPC; k++) begin
            if (k > 0) @(negedge clk);
            if (serial_out !== bits[k / BPC]) bad_line++;
            if (busy !== 1'b1) bad_busy++;
            if ((k % BPC) == BPC / 2 && (k / BPC) >= 1 && (k / BPC) <= 8)
                got[(k / BPC) - 1] = serial_out;
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s data: got=%02h required=%02h", name, got, exp);
        end
        checks++;
        if (bad_line != 0) begin
            errors++;
            $display("FAIL %s waveform: %0d wrong line cycles, required 0", name, bad_line);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL %s busy: %0d low cycles in frame, required 0", name, bad_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL reset serial_out: got=%b required=1", serial_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got=%b required=0", busy);
        end
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset fifo_rd_en: got=%b required=0", fifo_rd_en);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_idle;
        int rd_hi;
        int line_lo;
        int busy_hi;
        rd_hi = 0; line_lo = 0; busy_hi = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) rd_hi++;
            if (serial_out !== 1'b1) line_lo++;
            if (busy !== 1'b0) busy_hi++;
        end
        checks++;
        if (rd_hi != 0) begin
            errors++;
            $display("FAIL empty rd_en: %0d high cycles, required 0", rd_hi);
        end
        checks++;
        if (line_lo != 0) begin
            errors++;
            $display("FAIL empty serial_out: %0d low cycles, required 0", line_lo);
        end
        checks++;
        if (busy_hi != 0) begin
            errors++;
            $display("FAIL empty busy: %0d high cycles, required 0", busy_hi);
        end
    endtask

    task automatic test_single;
        int rd0;
        rd0 = rd_cnt;
        push(8'hA5);
        rx_check("single_a5");
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single post-frame: serial_out=%b busy=%b required 1/0", serial_out, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rd_cnt - rd0 != 1) begin
            errors++;
            $display("FAIL single rd_en pulses: got=%0d required=1", rd_cnt - rd0);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        push(8'h01);
        push(8'hFF);
        rx_check("b2b_01");
        gap = 0;
        @(negedge clk);
        while (serial_out === 1'b1 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        checks++;
        if (gap != 2) begin
            errors++;
            $display("FAIL b2b gap: got=%0d cycles required=2", gap);
        end
        rx_check("b2b_ff");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int t;
        push(8'h3C);
        push(8'h5A);
        t = 0;
        while (serial_out !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst start timeout: serial_out=%b required 0", serial_out);
        end
        repeat (BPC * 4 + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst async: serial_out=%b busy=%b rd_en=%b required 1/0/0",
                     serial_out, busy, fifo_rd_en);
        end
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst release rd_en: got=%b required=0", fifo_rd_en);
        end
        rx_check("after_reset_5a");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_empty_idle();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (rd_en_bad != 0) begin
            errors++;
            $display("FAIL rd_en legality: %0d strobes while empty or busy, required 0", rd_en_bad);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
